// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle multiply/divide unit for the EX stage, holding the
// architectural HI/LO registers.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   stall           pipeline stall bus; bit EX_IDX holds EX in DONE
//   flush           cancel any in-flight operation, results discarded
//   op_valid, op    EX instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   src_a, src_b    rs / rt operands
//   stallreq        hold IF..EX while an operation is in flight
//   busy            FSM not IDLE
//   hi, lo          HI/LO registers
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting; start of mul/div, or MTHI/MTLO write
// MUL   | multiply latency countdown, product written on last cycle
// DIV   | one restoring iteration per cycle, result written on last
// DONE  | result visible; hold until EX is released by the stall bus
module ex_muldiv #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2,
    parameter int STALL_W    = 6,
    parameter int EX_IDX     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               op_valid,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic               stallreq,
    output logic               busy,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int CNT_W = $clog2(WIDTH + MUL_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;      // multiplier, or divisor magnitude
    logic               signed_q;
    logic [WIDTH-1:0]   quot_q;   // dividend magnitude shifting into quotient
    logic [WIDTH-1:0]   rem_q;
    logic               neg_q;
    logic               neg_r;
    logic [CNT_W-1:0]   cnt;

    logic               start;
    logic               is_mul;
    logic               mt_write;

    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               mul_signed;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   q_next;
    logic [WIDTH-1:0]   r_next;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    logic               unused_stall;

    assign unused_stall = ^stall;

    assign start    = (state == S_IDLE) && op_valid && !op[2] && !flush;
    assign is_mul   = !op[1];
    assign mt_write = (state == S_IDLE) && op_valid && !flush;

    assign stallreq = !flush && (start || state == S_MUL || state == S_DIV);
    assign busy     = (state != S_IDLE);

    // With MUL_CYCLES==1 the product is written at the start edge, so the
    // multiplier sees the live operands in IDLE and the latched ones later.
    assign mul_a      = (state == S_IDLE) ? src_a : a_q;
    assign mul_b      = (state == S_IDLE) ? src_b : b_q;
    assign mul_signed = (state == S_IDLE) ? (op == 3'd0) : signed_q;
    assign ext_a      = mul_signed ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a} : {{WIDTH{1'b0}}, mul_a};
    assign ext_b      = mul_signed ? {{WIDTH{mul_b[WIDTH-1]}}, mul_b} : {{WIDTH{1'b0}}, mul_b};
    assign product    = ext_a * ext_b;

    assign a_neg = (op == 3'd2) && src_a[WIDTH-1];
    assign b_neg = (op == 3'd2) && src_b[WIDTH-1];
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -src_b : src_b;

    // Restoring step: shift next dividend bit into the remainder, subtract
    // when it fits. MIN/-1 falls out naturally: quotient 2^(W-1) negates to MIN.
    assign rem_shift = {rem_q, quot_q[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, b_q};
    assign q_next    = {quot_q[WIDTH-2:0], !diff[WIDTH]};
    assign r_next    = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_fix     = neg_q ? -q_next : q_next;
    assign r_fix     = neg_r ? -r_next : r_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            hi       <= '0;
            lo       <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            quot_q   <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            if (MUL_CYCLES == 1) begin
                                hi    <= product[2*WIDTH-1:WIDTH];
                                lo    <= product[WIDTH-1:0];
                                state <= S_DONE;
                            end else begin
                                a_q      <= src_a;
                                b_q      <= src_b;
                                signed_q <= (op == 3'd0);
                                cnt      <= CNT_W'(MUL_CYCLES > 1 ? MUL_CYCLES - 2 : 0);
                                state    <= S_MUL;
                            end
                        end else if (src_b == '0) begin
                            hi    <= src_a;
                            lo    <= '1;
                            state <= S_DONE;
                        end else begin
                            quot_q <= a_mag;
                            b_q    <= b_mag;
                            rem_q  <= '0;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            cnt    <= CNT_W'(WIDTH - 1);
                            state  <= S_DIV;
                        end
                    end else if (mt_write) begin
                        if (op == 3'd4) hi <= src_a;
                        if (op == 3'd5) lo <= src_a;
                    end
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        hi    <= product[2*WIDTH-1:WIDTH];
                        lo    <= product[WIDTH-1:0];
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DIV: begin
                    quot_q <= q_next;
                    rem_q  <= r_next;
                    if (cnt == '0) begin
                        hi    <= r_fix;
                        lo    <= q_fix;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (!stall[EX_IDX]) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Parametrised multi-cycle multiply/divide unit for the EX stage, with architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the instruction held in EX and raises stallreq while an operation is in flight. It holds the pipeline through the stall bus until the HI/LO results are written. Successor to the single-cycle ALU-only EX datapath; it adds width generality, configurable multiply latency, an iterative divider and flush cancellation.

Parameters:
WIDTH, 32, operand/HI/LO width (even, >=8)
MUL_CYCLES, 2, stallreq cycles for a multiply (>=1)
STALL_W, 6, stall bus width
EX_IDX, 2, stall bus bit owned by EX; 1 = Stop, 0 = NoStop

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall  in  STALL_W  pipeline stall bus
flush  in  1  cancel in-flight operation
op_valid  in  1  EX instruction is a mul/div/mthi/mtlo
op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (ignored)
src_a  in  WIDTH  rs operand / dividend / MTHI-MTLO data
src_b  in  WIDTH  rt operand / divisor
stallreq  out  1  request to hold IF..EX
busy  out  1  FSM not IDLE
hi  out  WIDTH  HI register (registered)
lo  out  WIDTH  LO register (registered)

Behaviour:
- Reset: state IDLE; hi=0, lo=0, busy=0, stallreq=0; counters and operand latches cleared. Reset overrides flush and start.
- States:
  - IDLE, MUL, DIV, DONE.
  - busy = (state != IDLE).
- Start (IDLE & op_valid & op in 0..3 & !flush):
  - Latch src_a and src_b.
  - stallreq=1 combinationally in this cycle.
  - Next state is MUL or DIV; divide-by-zero case below.
- Stall window: stallreq stays high for exactly N consecutive cycles, counting the start cycle. HI/LO are written at the clock edge ending cycle N; the state is then DONE.
  - Multiply: N = MUL_CYCLES.
  - Divide: N = WIDTH+1 (1 setup cycle taking magnitudes, then WIDTH restoring iterations; sign fix is applied at the final write).
  - Divide by zero (src_b==0): N=1; lo = all ones, hi = src_a; applies to DIV and DIVU.
- Multiply result: full 2*WIDTH-bit product; hi = upper half, lo = lower half. MULT is signed x signed; MULTU is unsigned.
- Divide result:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIV with MIN / -1 gives lo = MIN, hi = 0, no trap.
- DONE:
  - stallreq=0.
  - op_valid is ignored, so the same EX instruction never restarts.
  - Stay in DONE while stall[EX_IDX]==1; go to IDLE when stall[EX_IDX]==0.
- MTHI/MTLO (IDLE & op_valid & !flush): write src_a into hi or lo at the clock edge. No stallreq, no state change. Repeating under an external stall is harmless.
- op_valid in MUL/DIV: ignored.
- Reserved op codes: no effect anywhere.
- Flush in any state: next state IDLE, stallreq=0 in that cycle, hi/lo unchanged.
  - Flush has priority over a result write in the same cycle; the result is discarded.
  - A start coinciding with flush is suppressed.
- stallreq is combinational from state, start conditions and flush. hi/lo are purely registered.

Test Plan:
- MULT src_a=0xFFFFFFFE, src_b=3, MUL_CYCLES=2 -> stallreq high exactly 2 cycles; next cycle DONE with hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIVU 100/7 -> stallreq high 33 cycles; then lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> stallreq 1 cycle; lo=0xFFFFFFFF, hi=5.
- flush at cycle 10 of DIV with hi=lo=0x12345678 preloaded via MTHI/MTLO -> stallreq drops that cycle, state IDLE, hi/lo remain 0x12345678.
- MULT completes while stall[EX_IDX] is held high 3 extra cycles with op_valid still asserted -> stays in DONE, no restart, hi/lo written once. Next, MTLO 0xA5A5A5A5 -> lo updates in 1 cycle, stallreq never asserted.
